// File: rtl/button_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_led_ctrl
// Description : Button synchroniser/debouncer with press pulses. It drives the
//               LEDs in momentary, toggle or up/down-count mode. Optional PWM
//               dimming of the LEDs is enabled by the macro BTN_LED_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_led_ctrl #(
    parameter int NUM_BTN         = 5,
    parameter int NUM_LED         = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [1:0]         mode,
`ifdef BTN_LED_PWM_EN
    input  logic [7:0]         duty,
`endif
    output logic [NUM_LED-1:0] led,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press
);

    localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       c_MODE_MOM  = 2'b00;
    localparam logic [1:0]       c_MODE_TOG  = 2'b01;
    localparam logic [1:0]       c_MODE_CNT  = 2'b10;

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] w_accept;
    logic [NUM_BTN-1:0] r_tog;
    logic [NUM_LED-1:0] r_cnt_val;
    logic [NUM_LED-1:0] r_led;
    logic [NUM_LED-1:0] w_led_next;
    logic               w_inc;
    logic               w_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronised level agrees with the accepted one restarts the run.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        logic [CNT_W-1:0] r_db_cnt;
        logic             w_differ;

        assign w_differ    = r_sync2[i] ^ btn_state[i];
        assign w_accept[i] = w_differ && (r_db_cnt == c_DB_LAST);

        always_ff @(posedge clk) begin
            if (!rst_n || !w_differ || w_accept[i]) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_state <= '0;
            btn_press <= '0;
        end else begin
            btn_state <= btn_state ^ w_accept;
            btn_press <= w_accept & r_sync2;
        end
    end

    assign w_inc = btn_press[0] & ~btn_press[1];
    assign w_dec = btn_press[1] & ~btn_press[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tog     <= '0;
            r_cnt_val <= '0;
        end else begin
            r_tog <= r_tog ^ btn_press;
            if (btn_press[2]) begin
                r_cnt_val <= '0;
            end else if (w_inc) begin
                r_cnt_val <= r_cnt_val + NUM_LED'(1);
            end else if (w_dec) begin
                r_cnt_val <= r_cnt_val - NUM_LED'(1);
            end
        end
    end

    always_comb begin
        w_led_next = '0;
        case (mode)
            c_MODE_MOM: w_led_next = NUM_LED'(btn_state);
            c_MODE_TOG: w_led_next = NUM_LED'(r_tog);
            c_MODE_CNT: w_led_next = r_cnt_val;
            default:    w_led_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

`ifdef BTN_LED_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic       r_pwm_on;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_pwm_on  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm_on  <= (r_pwm_cnt < duty);
        end
    end

    assign led = r_led & {NUM_LED{r_pwm_on}};
`else
    assign led = r_led;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_led_ctrl
// Description : Self-checking bench for button_led_ctrl, directed + random,
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_led_ctrl;

    localparam int NB = 5;
    localparam int NL = 8;
    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic [1:0]    mode   = 2'b00;
`ifdef BTN_LED_PWM_EN
    logic [7:0]    duty   = 8'd255;
`endif
    logic [NL-1:0] led;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;

    int n_checks = 0;
    int n_pass   = 0;

    button_led_ctrl #(
        .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .mode(mode),
`ifdef BTN_LED_PWM_EN
        .duty(duty),
`endif
        .led(led),
        .btn_state(btn_state),
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    // Reference model: pins pass a 2-deep delay, and a channel flips once the
    // delayed pin has disagreed with it for DB consecutive cycles.
    logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_press = '0, m_tog = '0;
    int            m_run[NB];
    int            m_cnt = 0;
    logic [NL-1:0] m_led = '0;
    int            m_pwm = 0;
    bit            m_pwm_on = 1'b0;

    task automatic model_step();
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_tog = '0;
            m_cnt = 0; m_led = '0; m_pwm = 0; m_pwm_on = 1'b0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            case (mode)
                2'd0:    m_led = NL'(m_state);
                2'd1:    m_led = NL'(m_tog);
                2'd2:    m_led = NL'(m_cnt);
                default: m_led = '0;
            endcase
`ifdef BTN_LED_PWM_EN
            m_pwm_on = (m_pwm < int'(duty));
`endif
            m_pwm = (m_pwm + 1) % 256;
            if (m_press[2])                     m_cnt = 0;
            else if (m_press[0] && !m_press[1]) m_cnt = (m_cnt + 1) % 256;
            else if (m_press[1] && !m_press[0]) m_cnt = (m_cnt + 255) % 256;
            m_tog   = m_tog ^ m_press;
            m_press = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_state[i] = m_s2[i];
                        m_press[i] = m_s2[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    endtask

    function automatic logic [NL-1:0] gate(input logic [NL-1:0] v);
`ifdef BTN_LED_PWM_EN
        return v & {NL{m_pwm_on}};
`else
        return v;
`endif
    endfunction

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_in = '0;
        cycle(2);
        rst_n = 1'b1;
        cycle(1);
    endtask

    task automatic press_mask(input logic [NB-1:0] m);
        btn_in = m;
        cycle(DB + 4);
        btn_in = '0;
        cycle(DB + 5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) rst_n = 1'b1;
            btn_in = ~btn_in;
            cycle(1);
            n_checks++;
            if (led !== '0 || btn_state !== '0 || btn_press !== '0)
                $display("FAIL reset_outputs k=%0d: led=%h state=%b press=%b, required all 0", k, led, btn_state, btn_press);
            else n_pass++;
        end
        btn_in = '0;
        cycle(DB + 4);
    endtask

    task automatic test_debounce();
        do_reset();
        mode = 2'b00;
        for (int g = 0; g < 3; g++) begin
            btn_in[0] = 1'b1;
            cycle(1);
            btn_in[0] = 1'b0;
            for (int k = 0; k < DB + 1; k++) begin
                cycle(1);
                n_checks++;
                if (btn_state !== '0 || btn_press !== '0)
                    $display("FAIL glitch_rejected g=%0d: state=%b press=%b, required 0", g, btn_state, btn_press);
                else n_pass++;
            end
        end
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 2 + DB; k++) begin
            cycle(1);
            n_checks++;
            if (btn_state[0] !== (k >= 2 + DB) || btn_press[0] !== (k == 2 + DB))
                $display("FAIL press_latency k=%0d: state0=%b press0=%b, required %b/%b",
                         k, btn_state[0], btn_press[0], k >= 2 + DB, k == 2 + DB);
            else n_pass++;
        end
        cycle(1);
        n_checks++;
        if (led !== gate(8'h01) || btn_press !== '0)
            $display("FAIL momentary_led: led=%h press=%b, required %h/0", led, btn_press, gate(8'h01));
        else n_pass++;
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 2 + DB + 1; k++) begin
            cycle(1);
            n_checks++;
            if (btn_press !== '0 || btn_state[0] !== (k < 2 + DB))
                $display("FAIL release_no_pulse k=%0d: press=%b state0=%b", k, btn_press, btn_state[0]);
            else n_pass++;
        end
    endtask

    task automatic test_toggle();
        do_reset();
        mode = 2'b01;
        press_mask(5'b00010);
        n_checks++;
        if (led !== gate(8'h02)) $display("FAIL toggle_first: led=%h required %h", led, gate(8'h02));
        else n_pass++;
        press_mask(5'b00010);
        n_checks++;
        if (led !== gate(8'h00)) $display("FAIL toggle_second: led=%h required %h", led, gate(8'h00));
        else n_pass++;
        press_mask(5'b00010);
        mode = 2'b00;
        cycle(2);
        n_checks++;
        if (led !== gate(8'h00)) $display("FAIL toggle_mode00: led=%h required %h", led, gate(8'h00));
        else n_pass++;
        mode = 2'b01;
        cycle(2);
        n_checks++;
        if (led !== gate(8'h02)) $display("FAIL toggle_preserved: led=%h required %h", led, gate(8'h02));
        else n_pass++;
    endtask

    task automatic test_count();
        do_reset();
        mode = 2'b10;
        repeat (3) press_mask(5'b00001);
        n_checks++;
        if (led !== gate(8'd3)) $display("FAIL count_up3: led=%h required %h", led, gate(8'd3));
        else n_pass++;
        press_mask(5'b00100);
        press_mask(5'b00010);
        n_checks++;
        if (led !== gate(8'hFF)) $display("FAIL count_wrap_down: led=%h required %h", led, gate(8'hFF));
        else n_pass++;
        press_mask(5'b00011);
        n_checks++;
        if (led !== gate(8'hFF)) $display("FAIL count_up_down_same: led=%h required %h", led, gate(8'hFF));
        else n_pass++;
        press_mask(5'b00101);
        n_checks++;
        if (led !== gate(8'h00)) $display("FAIL count_clear_priority: led=%h required %h", led, gate(8'h00));
        else n_pass++;
        mode = 2'b11;
        press_mask(5'b00001);
        mode = 2'b10;
        cycle(2);
        n_checks++;
        if (led !== gate(8'h01)) $display("FAIL count_in_other_mode: led=%h required %h", led, gate(8'h01));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 2'b00;
        btn_in[0] = 1'b1;
        cycle(4);
        rst_n = 1'b0;
        cycle(1);
        n_checks++;
        if (btn_state !== '0 || led !== '0)
            $display("FAIL mid_reset_clear: state=%b led=%h required 0", btn_state, led);
        else n_pass++;
        rst_n = 1'b1;
        for (int k = 1; k <= 2 + DB; k++) begin
            cycle(1);
            n_checks++;
            if (btn_state[0] !== (k >= 2 + DB))
                $display("FAIL mid_reset_restart k=%0d: state0=%b required %b", k, btn_state[0], k >= 2 + DB);
            else n_pass++;
        end
        btn_in = '0;
        cycle(DB + 4);
    endtask

    task automatic test_random();
        int hold[NB];
        do_reset();
        for (int i = 0; i < NB; i++) hold[i] = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_in[i] = ~btn_in[i];
                    hold[i]   = int'($urandom_range(1, 10));
                end
            end
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 299) != 0);
            cycle(1);
            n_checks++;
            if (led !== gate(m_led) || btn_state !== m_state || btn_press !== m_press)
                $display("FAIL random c=%0d: led=%h state=%b press=%b, required %h/%b/%b",
                         c, led, btn_state, btn_press, gate(m_led), m_state, m_press);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

`ifdef BTN_LED_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        do_reset();
        mode = 2'b00;
        btn_in = 5'b00001;
        cycle(DB + 6);
        duty = 8'd64;
        cycle(2);
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cycle(1);
            if (led[0]) on_cnt++;
        end
        n_checks++;
        if (on_cnt !== 64) $display("FAIL pwm_duty64: on=%0d required 64", on_cnt);
        else n_pass++;
        duty = 8'd0;
        cycle(2);
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cycle(1);
            if (led[0]) on_cnt++;
        end
        n_checks++;
        if (on_cnt !== 0) $display("FAIL pwm_duty0: on=%0d required 0", on_cnt);
        else n_pass++;
        duty = 8'd255;
        btn_in = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        @(negedge clk);
        test_reset();
        test_debounce();
        test_toggle();
        test_count();
        test_reset_mid();
        test_random();
`ifdef BTN_LED_PWM_EN
        test_pwm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_led_ctrl.md
Name: button_led_ctrl

Overview:
Parametrised successor to the direct button-to-LED wiring in the board top level. Synchronises and debounces NUM_BTN raw button inputs and produces one-cycle press pulses. Drives NUM_LED registered LEDs in one of three selectable modes: momentary, toggle, or up/down counter. Instantiated in the top level between the button pins and the LED pins.

Parameters:
NUM_BTN, 5, number of button channels; 3 <= NUM_BTN <= NUM_LED
NUM_LED, 8, number of LED outputs; also the counter width
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 2
CNT_W, 20, debounce counter width; 2^CNT_W must be > DEBOUNCE_CYCLES

Ports:
clk  input  1  100 MHz system clock
rst_n  input  1  reset, synchronous, active-low
btn_in  input  NUM_BTN  raw asynchronous button levels, 1 = pressed
mode  input  2  00 momentary, 01 toggle, 10 count, 11 reserved
led  output  NUM_LED  registered LED drive
btn_state  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse on debounced 0->1
duty  input  8  PWM duty; present only with BTN_LED_PWM_EN

Behaviour:
- Reset is sampled on the clk edge while rst_n = 0. It clears synchronisers, debounce counters, btn_state, btn_press, toggle registers, the count register, the PWM counter and led. All outputs are 0 during reset and on the first cycle after release.
- Synchroniser: two flip-flops per channel. The debounce logic sees btn_in delayed by 2 cycles.
- Debounce, per channel:
  - sync == btn_state: counter <= 0.
  - sync != btn_state and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != btn_state and counter == DEBOUNCE_CYCLES-1: btn_state <= sync and counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Pin-to-btn_state latency is exactly 2 + DEBOUNCE_CYCLES cycles.
- btn_press[i] is high for exactly one cycle: the cycle after btn_state[i] goes 0->1. Releases produce no pulse.
- Toggle registers tog[NUM_BTN-1:0]: tog[i] flips on btn_press[i]. They update in every mode, not only in toggle mode.
- Count register cnt[NUM_LED-1:0], updated in every mode:
  - btn_press[2]: cnt <= 0. Clear has highest priority.
  - Otherwise btn_press[0] alone: cnt <= cnt+1, wrapping all-ones to 0.
  - Otherwise btn_press[1] alone: cnt <= cnt-1, wrapping 0 to all-ones.
  - btn_press[0] and btn_press[1] in the same cycle: cnt unchanged.
- LED register, one cycle after the source changes:
  - mode 00: led <= zero-extended btn_state.
  - mode 01: led <= zero-extended tog.
  - mode 10: led <= cnt.
  - mode 11: led <= 0.
- mode is sampled every cycle with no handshake. A mode change takes effect on led one cycle later. tog and cnt are never cleared by a mode change.
- Reset in mid-debounce discards the partial count. After release, a held button needs the full 2 + DEBOUNCE_CYCLES cycles again.
- Simultaneous presses on different channels are all accepted in the same cycle.

Optional Feature:
Macro BTN_LED_PWM_EN.
- Defined:
  - Adds the duty[7:0] input and an 8-bit free-running PWM counter (reset 0, wraps 255->0).
  - led output = led register AND (pwm_cnt < duty), replicated across all bits.
  - duty = 0 forces led to 0. duty = 255 gives 255 of 256 cycles on.
  - The comparison is registered, so gating adds no extra latency beyond the led register.
- Not defined: the duty port is absent and led is the led register directly.

Test Plan:
(All directed tests use DEBOUNCE_CYCLES = 4.)
1. Hold rst_n = 0 for 3 cycles while btn_in toggles every cycle -> led, btn_state and btn_press all 0 throughout and 1 cycle after release.
2. Mode 00: three 1-cycle glitches on btn_in[0] -> btn_state stays 0 and no pulse. Then hold btn_in[0] = 1 -> btn_state[0] = 1 exactly 6 cycles after the edge, btn_press[0] high for 1 cycle, led = 8'h01 one cycle later.
3. Mode 01: press and release btn1 twice -> led = 8'h02 after the first press, 8'h00 after the second. Switch to 00 then back to 01 -> tog preserved.
4. Mode 10: press btn0 three times -> led = 3. Clear with btn2, then press btn1 -> led = 8'hFF. Simultaneous btn0 + btn1 press -> led unchanged. btn2 + btn0 together -> led = 0.
5. Assert rst_n = 0 for 1 cycle at debounce count 2 with btn0 held -> btn_state[0] rises only 6 cycles after reset release.
6. BTN_LED_PWM_EN defined, mode 00, btn0 held, duty = 64 -> led[0] high for exactly 64 of every 256 cycles. duty = 0 -> led[0] never high.
